lsu_port: RTL and testbench

- Load/store unit that sits directly upstream of port B of the dual-port data RAM and is the only driver of that port.
- Accepts one RV32 load/store request at a time from the execute stage over a valid/ready handshake.
- Builds the word address, write strobe and lane-shifted write data, and extracts and sign/zero-extends load data.
- Returns a registered response with an error flag for misaligned, out-of-range or illegal accesses.

---
 rtl/lsu_port.sv | 158 +++++++++++++++
 tb/tb_lsu_port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port.sv
// lsu_port: single-outstanding RV32 load/store unit driving port B of the data RAM.
//
// One request is accepted in IDLE, the RAM is accessed for exactly one cycle in
// ACCESS, and a registered response is held in RESP until consumed. Misaligned,
// out-of-range and illegal-funct3 accesses never write the RAM and return
// resp_err=1 with resp_rdata=0.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we, req_funct3           store/load select and RV32 access size/sign
//   req_addr, req_wdata          byte address, right-aligned store data
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         extended load data (0 for stores/errors), fault flag
//   mem_wr_en, mem_wr_strobe     RAM port B write enable and byte lanes
//   mem_addr, mem_wdata          RAM port B word address and lane-replicated data
//   mem_rdata                    RAM port B combinational read data
module lsu_port #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [3:0]            mem_wr_strobe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        req_err;
  logic        we_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  off_p0;
  logic        err_p0;
  logic [31:0] rdata_p1;

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [31:0] ext;
    b   = word[{off, 3'b000} +: 8];
    h   = off[1] ? word[31:16] : word[15:0];
    bs  = signed'(b);
    hs  = signed'(h);
    case (f3)
      3'b000:  ext = bs;
      3'b001:  ext = hs;
      3'b010:  ext = signed'(word);
      3'b100:  ext = signed'({24'd0, b});
      3'b101:  ext = signed'({16'd0, h});
      default: ext = '0;
    endcase
    return unsigned'(ext);
  endfunction

  assign accept = (state == IDLE) && req_valid;

  // Fault classification is done once, on the request as presented.
  always_comb begin
    logic legal;
    logic misalign;
    logic range_err;
    legal     = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    range_err = |(req_addr >> (ADDR_WIDTH + 2));
    req_err   = !legal || misalign || range_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request capture. mem_addr/mem_wdata load here so they are valid
  // throughout ACCESS and hold their value until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p0     <= 1'b0;
      funct3_p0 <= 3'b000;
      off_p0    <= 2'b00;
      err_p0    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      we_p0     <= req_we;
      funct3_p0 <= req_funct3;
      off_p0    <= req_addr[1:0];
      err_p0    <= req_err;
      mem_addr  <= req_addr[ADDR_WIDTH+1:2];
      mem_wdata <= store_lanes(req_funct3, req_wdata);
    end
  end

  // Stage p1: load data sampled at the end of ACCESS, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
    end else if (state == ACCESS) begin
      rdata_p1 <= (!we_p0 && !err_p0) ? load_fmt(funct3_p0, off_p0, mem_rdata) : 32'd0;
    end
  end

  // Write enable decodes straight from state so an asynchronous reset kills
  // an in-flight store in the same cycle.
  assign mem_wr_en     = (state == ACCESS) && we_p0 && !err_p0;
  assign mem_wr_strobe = mem_wr_en ? store_strobe(funct3_p0, off_p0) : 4'b0000;
  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign resp_err      = resp_valid && err_p0;
  assign resp_rdata    = rdata_p1;

endmodule

// File: tb/tb_lsu_port.sv
module tb_lsu_port;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_wr_en;
  logic [3:0]    mem_wr_strobe;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  lsu_port #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_wr_strobe(mem_wr_strobe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Port-B RAM stand-in: combinational read, byte-lane write on rising edge.
  logic [31:0] ram [0:(1<<AW)-1];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk)
    if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (mem_wr_strobe[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];

  // Reference model: flat byte-addressed memory, access rules in plain arithmetic.
  bit [7:0] ref_mem [bit [31:0]];

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [31:0] wd, output bit err, output bit [31:0] rd,
                                output bit [3:0] strb, output bit [31:0] lanes);
    int size;
    bit legal;
    bit [31:0] val;
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    legal = (size != 0) && !(f3[2] && (we || size == 4));
    err = !legal || (addr >= (32'd1 << (AW + 2)));
    if (legal && (addr % size) != 0) err = 1'b1;
    rd = 0; strb = 0; lanes = 0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) begin
          ref_mem[addr + i] = wd[8*i +: 8];
          strb[(addr % 4) + i] = 1'b1;
        end
        for (int i = 0; i < 4; i++) lanes[8*i +: 8] = ref_rd((addr & ~32'd3) + i);
      end else begin
        val = 0;
        for (int i = 0; i < size; i++) val = val | (32'(ref_rd(addr + i)) << (8*i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
        rd = val;
      end
    end
  endfunction

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, observe ACCESS and RESP, consume the response.
  task automatic exec_and_check(input string tag, input bit we, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wd, input bit e_err,
                                input bit [31:0] e_rd, input bit [3:0] e_strb,
                                input bit [31:0] e_wd);
    int w;
    logic a_en; logic [3:0] a_strb; logic [31:0] a_wd; logic [AW-1:0] a_addr;
    logic [31:0] mask;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    a_en = mem_wr_en; a_strb = mem_wr_strobe; a_wd = mem_wdata; a_addr = mem_addr;
    @(posedge clk); #1;
    check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, " resp_err"},   {31'd0, resp_err}, {31'd0, e_err});
    check({tag, " resp_rdata"}, resp_rdata, e_rd);
    check({tag, " wr_en"},      {31'd0, a_en}, {31'd0, (we && !e_err)});
    check({tag, " strobe"},     {28'd0, a_strb}, {28'd0, e_strb});
    if (!e_err) check({tag, " mem_addr"}, {16'd0, a_addr}, {16'd0, addr[AW+1:2]});
    if (we && !e_err) begin
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{e_strb[i]}};
      check({tag, " mem_wdata"}, a_wd & mask, e_wd & mask);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " back to idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wd;
    bit        e_err;
    bit [31:0] e_rd;
    bit [3:0]  e_strb;
    bit [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m_err; bit [31:0] m_rd, m_lanes; bit [3:0] m_strb;
    bit [31:0] held;
    bit we; bit [2:0] f3; bit [31:0] addr, wd;
    int wr_seen;

    for (int i = 0; i < (1<<AW); i++) ram[i] = 32'd0;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;

    tbl.push_back('{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h13,       32'h000000A5, 1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5});
    tbl.push_back('{1'b0, 3'b000, 32'h13,       32'h0,        1'b0, 32'hFFFFFFA5, 4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 32'h13,       32'h0,        1'b0, 32'h000000A5, 4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h12,       32'h0,        1'b0, 32'hFFFFA5AD, 4'b0000, 32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h21,       32'h0000BEEF, 1'b1, 32'h0,        4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h22,       32'h0,        1'b1, 32'h0,        4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h00040000, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h20,       32'h00001234, 1'b0, 32'h0,        4'b0011, 32'h12341234});
    tbl.push_back('{1'b0, 3'b101, 32'h20,       32'h0,        1'b0, 32'h00001234, 4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b011, 32'h20,       32'h0,        1'b1, 32'h0,        4'b0000, 32'h0});
    tbl.push_back('{1'b1, 3'b100, 32'h20,       32'h0,        1'b1, 32'h0,        4'b0000, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 32'h00001234, 4'b0000, 32'h0});

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready",  {31'd0, req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_err",   {31'd0, resp_err}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst mem_wr_en",  {31'd0, mem_wr_en}, 32'd0);
    check("rst strobe",     {28'd0, mem_wr_strobe}, 32'd0);
    check("rst mem_addr",   {16'd0, mem_addr}, 32'd0);
    check("rst mem_wdata",  mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wr_seen = 0;
    repeat (4) begin @(negedge clk); if (mem_wr_en) wr_seen++; end
    check("idle no write", wr_seen, 0);
    check("idle req_ready", {31'd0, req_ready}, 32'd1);

    // Directed table
    foreach (tbl[k]) begin
      model(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wd, m_err, m_rd, m_strb, m_lanes);
      exec_and_check($sformatf("vec%0d", k), tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wd,
                     tbl[k].e_err, tbl[k].e_rd, tbl[k].e_strb, tbl[k].e_wd);
    end
    check("sh misaligned ram untouched", ram[8], 32'h00001234);

    // Backpressure on a load; a request offered meanwhile must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    held = resp_rdata;
    check("bp rdata", held, 32'hA5ADBEEF);
    for (int c = 0; c < 5; c++) begin
      check("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp stable",     resp_rdata, held);
      check("bp req_ready",  {31'd0, req_ready}, 32'd0);
      check("bp no write",   {31'd0, mem_wr_en}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp released idle", {30'd0, resp_valid, req_ready}, 32'd1);
    check("bp ignored store", ram[16], 32'd0);
    model(1'b0, 3'b010, 32'h20, 32'h0, m_err, m_rd, m_strb, m_lanes);
    exec_and_check("bp next", 1'b0, 3'b010, 32'h20, 32'h0, m_err, m_rd, m_strb, m_lanes);

    // Reset during the ACCESS cycle of a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid wr_en before rst", {31'd0, mem_wr_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid wr_en dropped", {31'd0, mem_wr_en}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid ram untouched", ram[12], 32'd0);
    model(1'b0, 3'b010, 32'h30, 32'h0, m_err, m_rd, m_strb, m_lanes);
    exec_and_check("mid reload", 1'b0, 3'b010, 32'h30, 32'h0, m_err, m_rd, m_strb, m_lanes);

    // Randomised traffic against the byte-level model
    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h40 + $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) addr = addr | (32'($urandom_range(1, 255)) << (AW + 2));
      wd   = $urandom;
      model(we, f3, addr, wd, m_err, m_rd, m_strb, m_lanes);
      exec_and_check($sformatf("rnd%0d", n), we, f3, addr, wd, m_err, m_rd, m_strb, m_lanes);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
